// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SEC/DED decoder.
// Overall-parity (DED) support is selected with the HAMMING_DED_EN macro.
package hamming_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    CORR  = 2'd1,
    UNC   = 2'd2
  } err_class_e;

`ifdef HAMMING_DED_EN
  localparam int unsigned DED_W = 1;
`else
  localparam int unsigned DED_W = 0;
`endif

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int unsigned hamming_p_w(input int unsigned data_w);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < 7; k++)
      if ((1 << p) < data_w + p + 1) p = p + 1;
    return p;
  endfunction

  // 1-based Hamming position of data bit idx (skips power-of-two slots).
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 1; p <= 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_dec_syndrome.sv
// Combinational Hamming syndrome (and overall parity when HAMMING_DED_EN
// is defined) over a received codeword; shareable with an encoder-side checker.
module hamming_syndrome #(
  parameter int unsigned CW_W = 8,
  parameter int unsigned P_W  = 3,
  parameter int unsigned HW   = 7
) (
  input  logic [CW_W-1:0] cw,
`ifdef HAMMING_DED_EN
  output logic            ov,
`endif
  output logic [P_W-1:0]  syn
);

  always_comb begin
    syn = '0;
    for (int unsigned i = 0; i < HW; i++)
      for (int unsigned k = 0; k < P_W; k++)
        if (((i + 1) & (1 << k)) != 0) syn[k] = syn[k] ^ cw[i];
  end

`ifdef HAMMING_DED_EN
  assign ov = ^cw;
`endif

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage pipelined Hamming SEC decoder with saturating error counters.
// Define HAMMING_DED_EN to add the overall parity bit and double-error detection.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned P_W    = hamming_p_w(DATA_W),
  localparam int unsigned CW_W   = DATA_W + P_W + DED_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [P_W-1:0]    out_syndrome,
  output logic              out_err_corr,
  output logic              out_err_unc,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  unc_cnt
);

  localparam int unsigned HW = DATA_W + P_W;

  logic              s1_valid, s2_valid;
  logic              s1_adv, s2_adv, out_hs;
  logic [HW-1:0]     s1_cw;
  logic [P_W-1:0]    s1_syn, syn_c;
  err_class_e        cls;
  logic [HW-1:0]     fixed;
  logic [DATA_W-1:0] data_c;
  logic              in_range;
`ifdef HAMMING_DED_EN
  logic              s1_ov, ov_c;
`endif

  hamming_syndrome #(.CW_W(CW_W), .P_W(P_W), .HW(HW)) u_syn (
    .cw  (in_cw),
`ifdef HAMMING_DED_EN
    .ov  (ov_c),
`endif
    .syn (syn_c)
  );

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_hs    = s2_valid && out_ready;

  always_comb begin
    in_range = (s1_syn != '0) && (int'(s1_syn) <= int'(HW));
`ifdef HAMMING_DED_EN
    // syn==0 with odd overall parity means only the parity bit itself flipped.
    if (s1_syn == '0)             cls = s1_ov ? CORR : CLEAN;
    else if (!s1_ov || !in_range) cls = UNC;
    else                          cls = CORR;
`else
    if (s1_syn == '0)      cls = CLEAN;
    else if (!in_range)    cls = UNC;
    else                   cls = CORR;
`endif
    fixed = s1_cw;
    for (int unsigned i = 0; i < HW; i++)
      if (cls == CORR && int'(s1_syn) == int'(i + 1)) fixed[i] = ~s1_cw[i];
    data_c = '0;
    for (int unsigned j = 0; j < DATA_W; j++)
      data_c[j] = fixed[data_pos(j) - 1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_cw        <= '0;
      s1_syn       <= '0;
`ifdef HAMMING_DED_EN
      s1_ov        <= 1'b0;
`endif
      s2_valid     <= 1'b0;
      out_data     <= '0;
      out_syndrome <= '0;
      out_err_corr <= 1'b0;
      out_err_unc  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_cw  <= in_cw[HW-1:0];
          s1_syn <= syn_c;
`ifdef HAMMING_DED_EN
          s1_ov  <= ov_c;
`endif
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data     <= data_c;
          out_syndrome <= s1_syn;
          out_err_corr <= (cls == CORR);
          out_err_unc  <= (cls == UNC);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else begin
      if (out_hs && out_err_corr && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_hs && out_err_unc  && unc_cnt  != '1) unc_cnt  <= unc_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed + scoreboard bench for hamming_secded_dec (DATA_W=4, CNT_W=2).
module tb_hamming_secded_dec;

`ifdef HAMMING_DED_EN
  localparam int DED = 1;
`else
  localparam int DED = 0;
`endif
  localparam int HW   = 7;
  localparam int CW_W = HW + DED;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] s;
    logic       c;
    logic       u;
  } exp_t;

  logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [CW_W-1:0] in_cw;
  logic [3:0]      out_data;
  logic [2:0]      out_syndrome;
  logic            out_err_corr, out_err_unc;
  logic [1:0]      corr_cnt, unc_cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int exp_corr = 0, exp_unc = 0;
  logic held = 1'b0;
  exp_t held_v;

  hamming_secded_dec #(.DATA_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_err_corr(out_err_corr), .out_err_unc(out_err_unc),
    .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .unc_cnt(unc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: syndrome as XOR of the positions of all set bits.
  function automatic exp_t model(input logic [CW_W-1:0] cw);
    exp_t e;
    int syn, di;
    logic ov;
    logic [HW-1:0] w;
    w = cw[HW-1:0];
    syn = 0;
    for (int p = 1; p <= HW; p++) if (w[p-1]) syn = syn ^ p;
    ov = ^cw;
    e.c = 1'b0;
    e.u = 1'b0;
    if (DED == 1 && syn == 0 && ov) e.c = 1'b1;
    else if (DED == 1 && syn != 0 && !ov) e.u = 1'b1;
    else if (syn != 0) begin
      e.c = 1'b1;
      w[syn-1] = ~w[syn-1];
    end
    di = 0;
    e.d = '0;
    for (int p = 1; p <= HW; p++)
      if ((p & (p - 1)) != 0) begin
        e.d[di] = w[p-1];
        di++;
      end
    e.s = 3'(syn);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_corr = 0;
      exp_unc  = 0;
      held     = 1'b0;
    end else begin
      exp_t e;
      chk("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
      chk("unc_cnt", 32'(unc_cnt), 32'(exp_unc));
      if (held) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_payload", {out_data, out_syndrome, out_err_corr, out_err_unc}, 32'(held_v));
        held = 1'b0;
      end
      e = '0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow got output %0h exp none", out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 32'(out_data), 32'(e.d));
          chk("sb_syn", 32'(out_syndrome), 32'(e.s));
          chk("sb_flags", {out_err_corr, out_err_unc}, {e.c, e.u});
        end
      end else if (out_valid) begin
        held   = 1'b1;
        held_v = {out_data, out_syndrome, out_err_corr, out_err_unc};
      end
      if (clr_cnt) begin
        exp_corr = 0;
        exp_unc  = 0;
      end else if (out_valid && out_ready) begin
        if (e.c && exp_corr != 3) exp_corr++;
        if (e.u && exp_unc != 3) exp_unc++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_cw));
    end
  end

  // Entry and exit at posedge+1 with an idle pipeline and out_ready=1.
  task automatic send_dir(input string tag, input logic [CW_W-1:0] cw, input logic [3:0] d,
                          input logic [2:0] s, input logic c, input logic u, input logic clr);
    in_valid = 1'b1;
    in_cw    = cw;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_cw    = CW_W'($urandom);
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_syn"}, 32'(out_syndrome), 32'(s));
    chk({tag, "_corr"}, 32'(out_err_corr), 32'(c));
    chk({tag, "_unc"}, 32'(out_err_unc), 32'(u));
    clr_cnt = clr;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain"}, 32'(sb.size()), 0);
  endtask

  initial begin
    logic [CW_W-1:0] w[4];
    int acc, cyc, drop_at;
    logic hs;

    rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_payload", {out_data, out_syndrome, out_err_corr, out_err_unc}, 0);
    chk("rst_cnts", {corr_cnt, unc_cnt}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef HAMMING_DED_EN
    send_dir("clean", 8'h55, 4'b1011, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("clean_cnt", {corr_cnt, unc_cnt}, 0);
    send_dir("pos5", 8'h45, 4'b1011, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("pos5_cnt", 32'(corr_cnt), 1);
    send_dir("dbl", 8'h56, 4'b1011, 3'd3, 1'b0, 1'b1, 1'b0);
    chk("dbl_cnt", 32'(unc_cnt), 1);
    send_dir("ovbit", 8'hD5, 4'b1011, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("ovbit_cnt", 32'(corr_cnt), 2);
`else
    send_dir("clean", 7'h55, 4'b1011, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("clean_cnt", {corr_cnt, unc_cnt}, 0);
    send_dir("pos5", 7'h45, 4'b1011, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("pos5_cnt", 32'(corr_cnt), 1);
    send_dir("dbl", 7'h56, 4'b1010, 3'd3, 1'b1, 1'b0, 1'b0);
    chk("dbl_cnt", 32'(corr_cnt), 2);
`endif

    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_cnts", {corr_cnt, unc_cnt}, 0);

    for (int i = 0; i < 5; i++)
      send_dir("sat", CW_W'(8'h45), 4'b1011, 3'd5, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", 32'(corr_cnt), 3);
    send_dir("clrwin", CW_W'(8'h45), 4'b1011, 3'd5, 1'b1, 1'b0, 1'b1);
    chk("clrwin_cnt", 32'(corr_cnt), 0);

    // Backpressure: out_ready low for 3 cycles while streaming 4 words.
    w[0] = CW_W'(8'h45); w[1] = CW_W'(8'h55); w[2] = CW_W'(8'h54); w[3] = CW_W'(8'h15);
    in_valid = 1'b1; in_cw = w[0]; out_ready = 1'b0;
    acc = 0; cyc = 0; drop_at = -1;
    while (acc < 4 && cyc < 50) begin
      @(negedge clk);
      if (!in_ready && drop_at < 0) drop_at = acc;
      hs = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        acc++;
        if (acc < 4) in_cw = w[acc];
        else in_valid = 1'b0;
      end
      if (cyc == 3) out_ready = 1'b1;
    end
    chk("bp_drop_after", 32'(drop_at), 2);
    chk("bp_accepted", 32'(acc), 4);
    drain("bp");

    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_cw     = CW_W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain("rand");

    in_valid = 1'b1; in_cw = CW_W'(8'h45); out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_cnts", {corr_cnt, unc_cnt}, 0);
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_out_valid", 32'(out_valid), 0);
    send_dir("postrst", CW_W'(8'h55), 4'b1011, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("postrst_cnts", {corr_cnt, unc_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamming_secded_dec.md
# hamming_secded_dec

Parametrised, pipelined Hamming single-error-correct decoder with optional double-error detection. It replaces the fixed 7-bit combinational parity checker in the receive datapath. It accepts codewords over a valid/ready handshake, computes the syndrome, corrects single-bit errors and emits data with error flags two cycles later. Saturating error counters are provided for link-health monitoring.

## Interface
- DATA_W, 4: data bits per codeword; legal range 1..57.
- CNT_W, 16: width of each error counter.
- P_W (localparam): smallest p with 2^p >= DATA_W+p+1; for DATA_W=4, P_W=3.
- CW_W (localparam): DATA_W+P_W, plus 1 when HAMMING_DED_EN is defined.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input codeword valid.
- in_ready  out  1  decoder can accept.
- in_cw  in  CW_W  received codeword.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  corrected data.
- out_syndrome  out  P_W  raw Hamming syndrome.
- out_err_corr  out  1  single error corrected.
- out_err_unc  out  1  uncorrectable error; data passed unmodified.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of accepted words with out_err_corr.
- unc_cnt  out  CNT_W  count of accepted words with out_err_unc.

## Operation
- Codeword layout: in_cw[i] holds Hamming position i+1 for i < DATA_W+P_W. Parity bits sit at power-of-two positions (1,2,4,…). Data bits d0.. fill the remaining positions in ascending order. With DED, in_cw[CW_W-1] is overall even parity of all other bits.
- Syndrome bit k is the XOR of all positions whose index has bit k set. A syndrome of 0 means no Hamming error.
- Classification without DED:
  - syn==0: clean.
  - 1 <= syn <= DATA_W+P_W: flip position syn; out_err_corr=1.
  - syn beyond the codeword length: out_err_unc=1, no flip.
- Classification with DED (ov = XOR of entire in_cw):
  - syn==0, ov==0: clean.
  - syn!=0, ov==1, syn in range: correct it; out_err_corr=1.
  - syn==0, ov==1: overall-parity bit in error; data clean; out_err_corr=1.
  - syn!=0, ov==0: double error; out_err_unc=1.
  - syn out of range: out_err_unc=1.
- out_err_corr and out_err_unc are never both 1.
- Counters:
  - Increment only on an output handshake (out_valid && out_ready) whose word carries the matching flag.
  - Saturate at all-ones.
  - clr_cnt wins over a same-cycle increment; the counter becomes 0.

## Timing
- Two register stages.
  - S1 registers the codeword, syndrome and ov.
  - S2 registers data, syndrome and flags.
- Latency is 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 word per cycle.
- Ready propagation:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready.
- The pipeline holds all payload stable while out_valid && !out_ready.
- Reset values: out_valid=0, out_data=0, out_syndrome=0, both flags 0, both counters 0, internal valids 0. in_ready reads 1 during and after reset.
- Reset mid-operation: in-flight words are discarded and not counted.
- in_cw is ignored whenever in_valid=0.

## Configuration
- HAMMING_DED_EN: when defined, CW_W includes the overall parity bit and the DED classification applies.
- When undefined: pure SEC. The ov logic is absent. out_err_unc is raised only for out-of-range syndromes.

## Structure
- Package hamming_pkg holds:
  - function hamming_p_w(data_w), returning P_W.
  - function data_pos(idx), mapping data index to Hamming position.
  - a typedef for error class (CLEAN, CORR, UNC).
- Sub-module hamming_syndrome: purely combinational, computes syndrome and ov from a codeword. It is reusable by a future encoder-side checker.

## Test plan
All scenarios use DATA_W=4 with HAMMING_DED_EN defined. The clean codeword for data 4'b1011 is 8'h55.
- Send 8'h55 -> 2 cycles later out_data=4'b1011, syndrome 0, both flags 0, counters unchanged.
- Send 8'h45 (position 5 flipped) -> out_data=4'b1011, syndrome 5, out_err_corr=1, corr_cnt=1.
- Send 8'h56 (positions 1 and 2 flipped) -> syndrome 3, out_err_unc=1, out_data uncorrected (4'b1011 here, since only parity bits are hit), unc_cnt=1.
- Send 8'hD5 (overall bit flipped) -> out_data=4'b1011, syndrome 0, out_err_corr=1.
- Stream 4 back-to-back words while out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, all 4 emerge in order, no duplicate counts.
- Preload corr_cnt with CNT_W=2 via 5 corrected words -> saturates at 3. Assert clr_cnt in the same cycle as a corrected handshake -> corr_cnt=0. Pulse rst_n low mid-stream -> out_valid=0 immediately.
